// File: rtl/scan_decoder_if.sv
// Control and output bundle of scan_decoder: enable gating, mode, select,
// scan timing inputs and the registered active-low decoder outputs.
interface scan_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 16
);
  localparam int N = 1 << SEL_W;

  logic [SEL_W-1:0]   sel_i;
  logic               g1_en_i;
  logic               g2a_en_n_i;
  logic               g2b_en_n_i;
  logic               mode_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [SEL_W-1:0]   last_i;
  logic [N-1:0]       yn_o;
  logic [SEL_W-1:0]   idx_o;
  logic               wrap_o;

  // No handshake: the controller holds levels, the decoder samples them every
  // rising edge and answers one cycle later.
  modport master (
    output sel_i, g1_en_i, g2a_en_n_i, g2b_en_n_i, mode_i, dwell_i, last_i,
    input  yn_o, idx_o, wrap_o
  );

  modport slave (
    input  sel_i, g1_en_i, g2a_en_n_i, g2b_en_n_i, mode_i, dwell_i, last_i,
    output yn_o, idx_o, wrap_o
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered 74138-style decoder with an added scan sequencer that walks the
// single low output across 0..last_i with a dwell and a break-before-make gap.
module scan_decoder #(
  parameter int SEL_W        = 3,
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  scan_decoder_if.slave       bus,
  output logic [1:0]          state_o
);
  localparam int N       = 1 << SEL_W;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] count;
  logic [BLANK_W-1:0] blank_cnt;
  logic [SEL_W-1:0]   idx;
  logic [N-1:0]       yn_q;
  logic               wrap_q;

  logic               en;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [N-1:0] dec_n(input logic [SEL_W-1:0] s);
    logic [N-1:0] r;
    r    = '1;
    r[s] = 1'b0;
    return r;
  endfunction

  assign en = bus.g1_en_i & ~bus.g2a_en_n_i & ~bus.g2b_en_n_i;
  // idx above a lowered last_i wraps on its next advance instead of running on.
  assign next_idx = (idx >= bus.last_i) ? '0 : idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      count     <= '0;
      blank_cnt <= '0;
      idx       <= '0;
      yn_q      <= '1;
      wrap_q    <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      count     <= '0;
      blank_cnt <= '0;
      idx       <= '0;
      yn_q      <= '1;
      wrap_q    <= 1'b0;
    end else if (!bus.mode_i) begin
      state     <= DIRECT;
      count     <= '0;
      blank_cnt <= '0;
      yn_q      <= dec_n(bus.sel_i);
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state)
        IDLE, DIRECT: begin
          state     <= SCAN_ON;
          idx       <= '0;
          count     <= '0;
          blank_cnt <= '0;
          yn_q      <= dec_n('0);
        end
        SCAN_ON: begin
          // >= lets a dwell_i lowered below the running count end the dwell now.
          if (count >= bus.dwell_i) begin
            if (BLANK_CYCLES > 0) begin
              state     <= SCAN_BLANK;
              blank_cnt <= '0;
              yn_q      <= '1;
            end else begin
              idx    <= next_idx;
              count  <= '0;
              yn_q   <= dec_n(next_idx);
              wrap_q <= (next_idx == '0);
            end
          end else begin
            count <= count + 1'b1;
            yn_q  <= dec_n(idx);
          end
        end
        SCAN_BLANK: begin
          if (int'(blank_cnt) >= BLANK_CYCLES - 1) begin
            state  <= SCAN_ON;
            idx    <= next_idx;
            count  <= '0;
            yn_q   <= dec_n(next_idx);
            wrap_q <= (next_idx == '0);
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
            yn_q      <= '1;
          end
        end
        default: begin
          state <= IDLE;
          yn_q  <= '1;
        end
      endcase
    end
  end

  assign bus.yn_o   = yn_q;
  assign bus.idx_o  = idx;
  assign bus.wrap_o = wrap_q;
  assign state_o    = state;
endmodule
